dpram_be: RTL and testbench

- Single-clock simple dual-port RAM (one write port, one read port) with per-byte write enables.
- Configurable read-during-write mode and 1- or 2-cycle read latency, with a valid strobe on read data.
- Hardware clear of the whole array after reset, flagged by a busy output.
- Generalised successor of the team's basic dual-port RAM. Used for register-file shadows, TLB/tag stores and scratch buffers in the CPU.

---
 rtl/dpram_pkg.sv | 30 +++
 rtl/dpram_be_rdpipe.sv | 49 ++++
 rtl/dpram_be.sv | 89 ++++++++
 tb/tb_dpram_be.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: read-during-write modes,
// clear FSM encoding and the byte-merge helper used by write and forwarding paths.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // merge_be works on a fixed maximum width; callers size-cast in and out.
    localparam int MERGE_MAX_W = 512;
    localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_B-1:0] be
    );
        logic [MERGE_MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MERGE_MAX_B; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_be_rdpipe.sv
// Read output pipeline: one or two register stages of data plus valid.
// Data registers only load on a valid beat, so rdata holds across idle cycles.
module dpram_be_rdpipe #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    logic             st_vld;
    logic [WIDTH-1:0] st_dat;

    if (RD_LATENCY == 2) begin : g_lat2
        logic             s1_vld;
        logic [WIDTH-1:0] s1_dat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld <= 1'b0;
                s1_dat <= '0;
            end else begin
                s1_vld <= req;
                if (req) s1_dat <= din;
            end
        end

        assign st_vld = s1_vld;
        assign st_dat = s1_dat;
    end else begin : g_lat1
        assign st_vld = req;
        assign st_dat = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= st_vld;
            if (st_vld) rdata <= st_dat;
        end
    end

endmodule

// File: rtl/dpram_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour, 1/2-cycle read latency and a post-reset hardware clear of the array.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int  DEPTH          = 16,
    parameter int  WIDTH          = 32,
    parameter int  RD_LATENCY     = 1,
    parameter int  RDW_MODE       = 0,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int AW             = $clog2(DEPTH),
    localparam int NB             = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             init_busy,
    input  logic             wen,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          ready;
    logic          wr_ok, rd_ok, rd_in_range, fwd;
    logic [WIDTH-1:0] wr_word, rd_old, rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_READY;
            default:  state_nxt = state;
        endcase
    end

    assign ready     = (state == ST_READY);
    assign init_busy = ~ready;

    // Addresses past DEPTH are dropped on write and read back as zero.
    assign wr_ok       = ready & wen & ({1'b0, waddr} < DEPTH_W);
    assign rd_ok       = ready & ren;
    assign rd_in_range = ({1'b0, raddr} < DEPTH_W);

    assign wr_word = WIDTH'(merge_be(MERGE_MAX_W'(mem[waddr]), MERGE_MAX_W'(wdata),
                                     MERGE_MAX_B'(wbe)));

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) mem[clr_cnt] <= '0;
        else if (wr_ok)        mem[waddr]   <= wr_word;
    end

    // Forwarding only touches the array-sample stage; wr_ok implies raddr is in range.
    assign rd_old  = rd_in_range ? mem[raddr] : '0;
    assign fwd     = (RDW_MODE == RDW_WRITE_FIRST) && wr_ok && (waddr == raddr);
    assign rd_word = fwd ? wr_word : rd_old;

    dpram_be_rdpipe #(
        .WIDTH      (WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rd_ok),
        .din    (rd_word),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: four configurations share one stimulus stream; each is
// tracked by a word-level memory model with per-instance latency and RDW rules.
module tb_dpram_be;

    localparam int N = 4;
    localparam int C_DEPTH[N] = '{16, 16, 12, 16};
    localparam int C_LAT[N]   = '{1, 2, 1, 2};
    localparam int C_RDW[N]   = '{0, 1, 1, 0};
    localparam int C_CLR[N]   = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [3:0]  wbe = '0, waddr = '0, raddr = '0;
    logic [31:0] wdata = '0;

    logic        busy [N];
    logic [31:0] rd   [N];
    logic        rv   [N];

    always #5 clk = ~clk;

    dpram_be #(.DEPTH(16), .WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[0]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]));
    dpram_be #(.DEPTH(16), .WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[1]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]));
    dpram_be #(.DEPTH(12), .WIDTH(32), .RD_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[2]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]));
    dpram_be #(.DEPTH(16), .WIDTH(32), .RD_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_d (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[3]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[3]), .rvalid(rv[3]));

    // ---------------- reference model ----------------
    logic [31:0] m_mem   [N][16];
    bit          m_known [N][16];
    int          m_busy  [N];
    bit          s_v [N][2];
    logic [31:0] s_d [N][2];
    bit          s_k [N][2];
    bit          e_v [N];
    logic [31:0] e_d [N];
    bit          e_k [N];

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit        wen;
        bit [3:0]  wbe;
        bit [3:0]  waddr;
        bit [31:0] wdata;
        bit        ren;
        bit [3:0]  raddr;
        bit        chk;
        bit [31:0] exp_rf;
        bit [31:0] exp_wf;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    function automatic vec_t mkv(bit we, bit [3:0] be, bit [3:0] wa, bit [31:0] wd,
                                 bit re, bit [3:0] ra, bit c, bit [31:0] rf, bit [31:0] wf);
        vec_t v;
        v.wen = we; v.wbe = be; v.waddr = wa; v.wdata = wd;
        v.ren = re; v.raddr = ra; v.chk = c; v.exp_rf = rf; v.exp_wf = wf;
        return v;
    endfunction

    function automatic logic [31:0] bmerge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, inst, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = (C_CLR[i] != 0) ? C_DEPTH[i] : 0;
            if (C_CLR[i] != 0)
                for (int a = 0; a < 16; a++) begin m_mem[i][a] = '0; m_known[i][a] = 1'b1; end
            for (int s = 0; s < 2; s++) begin s_v[i][s] = 1'b0; s_d[i][s] = '0; s_k[i][s] = 1'b1; end
            e_v[i] = 1'b0; e_d[i] = '0; e_k[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit v, k, wok;
        logic [31:0] d;
        int sel;
        for (int i = 0; i < N; i++) begin
            v = 1'b0; d = '0; k = 1'b1;
            if (m_busy[i] > 0) m_busy[i]--;
            else begin
                wok = wen && (int'(waddr) < C_DEPTH[i]);
                if (ren) begin
                    v = 1'b1;
                    if (int'(raddr) < C_DEPTH[i]) begin
                        d = m_mem[i][raddr]; k = m_known[i][raddr];
                        if (C_RDW[i] == 1 && wok && waddr == raddr) begin
                            d = bmerge(d, wdata, wbe); k = k || (wbe == 4'hF);
                        end
                    end
                end
                if (wok) begin
                    m_mem[i][waddr]   = bmerge(m_mem[i][waddr], wdata, wbe);
                    m_known[i][waddr] = m_known[i][waddr] || (wbe == 4'hF);
                end
            end
            s_v[i][1] = s_v[i][0]; s_d[i][1] = s_d[i][0]; s_k[i][1] = s_k[i][0];
            s_v[i][0] = v;         s_d[i][0] = d;         s_k[i][0] = k;
            sel = C_LAT[i] - 1;
            e_v[i] = s_v[i][sel];
            if (e_v[i]) begin e_d[i] = s_d[i][sel]; e_k[i] = s_k[i][sel]; end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("init_busy", i, busy[i], m_busy[i] > 0);
            chk("rvalid", i, rv[i], e_v[i]);
            if (e_k[i]) chk("rdata", i, rd[i], e_d[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_clear(string nm);
        int n;
        n = 0;
        while (busy[0] && n < 100) begin tick(); n++; end
        chk(nm, 0, n, 16);
    endtask

    task automatic async_reset_check(string nm);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk({nm, "_rdata"}, i, rd[i], 0);
            chk({nm, "_rvalid"}, i, rv[i], 0);
            chk({nm, "_busy"}, i, busy[i], C_CLR[i]);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int j, cnt;
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 16; a++) begin m_known[i][a] = 1'b0; m_mem[i][a] = 'x; end

        tbl[0]  = mkv(1, 'hF, 3, 'hDEADBEEF, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 'h5, 3, 'h11223344, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 1, 3, 1, 'hDE22BE44, 'hDE22BE44);
        tbl[3]  = mkv(1, 'hF, 7, 'hAAAAAAAA, 0, 0, 0, 0, 0);
        tbl[4]  = mkv(1, 'h3, 7, 'h12345678, 1, 7, 1, 'hAAAAAAAA, 'hAAAA5678);
        tbl[5]  = mkv(0, 0, 0, 0, 1, 7, 1, 'hAAAA5678, 'hAAAA5678);
        tbl[6]  = mkv(1, 'h0, 3, 'h00000000, 1, 3, 1, 'hDE22BE44, 'hDE22BE44);
        tbl[7]  = mkv(1, 'hF, 2, 'h0BADF00D, 1, 3, 1, 'hDE22BE44, 'hDE22BE44);
        tbl[8]  = mkv(0, 0, 0, 0, 1, 2, 1, 'h0BADF00D, 'h0BADF00D);
        tbl[9]  = mkv(1, 'hF, 2, 'h55555555, 1, 5, 1, 'h00000000, 'h00000000);
        tbl[10] = mkv(0, 0, 0, 0, 1, 2, 1, 'h55555555, 'h55555555);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset and clear; a read held during clear must be ignored.
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1; ren = 1'b1; raddr = 4'd5;
        wait_clear("clear_len");
        tick();
        chk("post_clear_rvalid", 0, rv[0], 1);
        chk("post_clear_rdata", 0, rd[0], 0);
        ren = 1'b0;
        tick();

        // Directed vectors: byte merge, read-during-write, latency-2 output stage isolation.
        for (int k = 0; k < NV; k++) begin
            wen = tbl[k].wen; wbe = tbl[k].wbe; waddr = tbl[k].waddr; wdata = tbl[k].wdata;
            ren = tbl[k].ren; raddr = tbl[k].raddr;
            tick();
            for (int i = 0; i < 3; i++) begin
                j = k - (C_LAT[i] - 1);
                if (j >= 0 && tbl[j].chk) begin
                    chk("tbl_rvalid", i, rv[i], 1);
                    chk("tbl_rdata", i, rd[i], (C_RDW[i] == 1) ? tbl[j].exp_wf : tbl[j].exp_rf);
                end
            end
        end

        // Burst: fill with addr*0x01010101, then read back-to-back.
        for (int a = 0; a < 16; a++) begin
            wen = 1'b1; wbe = 4'hF; waddr = 4'(a); wdata = a * 32'h01010101;
            tick();
        end
        wen = 1'b0;
        cnt = 0;
        for (int k = 0; k < 18; k++) begin
            ren = (k < 16); raddr = 4'(k);
            tick();
            chk("burst_rvalid", 0, rv[0], k < 16);
            if (rv[0]) begin chk("burst_rdata", 0, rd[0], cnt * 32'h01010101); cnt++; end
        end
        chk("burst_count", 0, cnt, 16);
        chk("burst_hold_rdata", 0, rd[0], 32'h0F0F0F0F);
        chk("burst_hold_rvalid", 0, rv[0], 0);

        // Out-of-range write/read on the DEPTH=12 instance.
        wen = 1'b1; wbe = 4'hF; waddr = 4'd13; wdata = 32'hFFFFFFFF; ren = 1'b0;
        tick();
        wen = 1'b0; ren = 1'b1; raddr = 4'd13;
        tick();
        chk("oor_rvalid", 2, rv[2], 1);
        chk("oor_rdata", 2, rd[2], 0);
        for (int a = 0; a < 12; a++) begin
            raddr = 4'(a);
            tick();
            chk("no_alias", 2, rd[2], a * 32'h01010101);
        end
        ren = 1'b0;
        tick();

        // Random traffic against the model, biased toward same-address collisions.
        repeat (400) begin
            wen = 1'($urandom_range(0, 1)); wbe = 4'($urandom); waddr = 4'($urandom);
            wdata = $urandom; ren = 1'($urandom_range(0, 1)); raddr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            tick();
        end
        wen = 1'b0; ren = 1'b0;
        tick();

        // Reset mid-clear restarts the full clear.
        async_reset_check("rst_a");
        ren = 1'b1; raddr = 4'd5;
        repeat (9) tick();
        async_reset_check("rst_b");
        wait_clear("reclear_len");
        ren = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
